// File: rtl/mat_vec_pkg.sv
// Shared types and helpers for the binary-vector by matrix engine.
package mat_vec_pkg;

   localparam int unsigned COEF_ROW_STRIDE = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_OUTPUT  = 2'd2
   } state_t;

   // Power-on coefficient for row/col; callers truncate to the coefficient width.
   function automatic int unsigned default_coef(input int unsigned row, input int unsigned col);
      return row * COEF_ROW_STRIDE + col + 1;
   endfunction

endpackage

// File: rtl/mat_vec_coef_rf.sv
// N x N coefficient register file: one write port, one combinational read port.
module mat_vec_coef_rf
   import mat_vec_pkg::*;
#(
   parameter int unsigned N  = 6,
   parameter int unsigned DW = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [$clog2(N)-1:0]   wr_row,
   input  logic [$clog2(N)-1:0]   wr_col,
   input  logic [DW-1:0]          wr_data,
   input  logic [$clog2(N)-1:0]   rd_row,
   input  logic [$clog2(N)-1:0]   rd_col,
   output logic [DW-1:0]          rd_data
);

   logic [DW-1:0] mem [N][N];

   // Reset restores the default matrix; write address is pre-qualified by the caller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               mem[i][j] <= DW'(default_coef(i, j));
            end
         end
      end else if (we) begin
         mem[wr_row][wr_col] <= wr_data;
      end
   end

   assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/mat_vec_engine.sv
// Binary vector times coefficient matrix: one MAC per cycle, results streamed by column.
module mat_vec_engine
   import mat_vec_pkg::*;
#(
   parameter int unsigned N  = 6,
   parameter int unsigned DW = 8,
   parameter int unsigned AW = DW + $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N-1:0]           in_vec,
   input  logic                   coef_we,
   input  logic [$clog2(N)-1:0]   coef_row,
   input  logic [$clog2(N)-1:0]   coef_col,
   input  logic [DW-1:0]          coef_data,
   output logic                   coef_err,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AW-1:0]          out_data,
   output logic [$clog2(N)-1:0]   out_idx,
   output logic                   out_last,
   output logic                   busy
);

   localparam int unsigned RW = $clog2(N);

   state_t          state_q, state_d;
   logic [N-1:0]    v_q, v_d;
   logic [RW-1:0]   row_q, row_d;
   logic [RW-1:0]   col_q, col_d;
   logic [AW-1:0]   acc_q, acc_d;

   logic            in_ready_d, busy_d, out_valid_d, out_last_d, coef_err_d;
   logic [AW-1:0]   out_data_d;
   logic [RW-1:0]   out_idx_d;

   logic            coef_addr_ok_c, coef_wr_c;
   logic [DW-1:0]   rd_data_c;
   logic [AW-1:0]   sum_c;

   // Writes only land in IDLE with an in-range address; anything else is flagged.
   assign coef_addr_ok_c = (32'(coef_row) < N) && (32'(coef_col) < N);
   assign coef_wr_c      = coef_we && (state_q == S_IDLE) && coef_addr_ok_c;
   assign sum_c          = acc_q + (v_q[row_q] ? AW'(rd_data_c) : AW'(0));

   mat_vec_coef_rf #(
      .N  (N),
      .DW (DW)
   ) u_coef_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (coef_wr_c),
      .wr_row  (coef_row),
      .wr_col  (coef_col),
      .wr_data (coef_data),
      .rd_row  (row_q),
      .rd_col  (col_q),
      .rd_data (rd_data_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         v_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         acc_q     <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         coef_err  <= 1'b0;
      end else begin
         state_q   <= state_d;
         v_q       <= v_d;
         row_q     <= row_d;
         col_q     <= col_d;
         acc_q     <= acc_d;
         in_ready  <= in_ready_d;
         busy      <= busy_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_idx   <= out_idx_d;
         out_last  <= out_last_d;
         coef_err  <= coef_err_d;
      end
   end

   // Next-state and next-output logic; outputs are loaded one edge ahead of their state.
   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      row_d       = row_q;
      col_d       = col_q;
      acc_d       = acc_q;
      in_ready_d  = in_ready;
      busy_d      = busy;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_idx_d   = out_idx;
      out_last_d  = out_last;
      coef_err_d  = coef_err | (coef_we & ~coef_wr_c);

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               v_d        = in_vec;
               row_d      = '0;
               col_d      = '0;
               acc_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_COMPUTE;
            end
         end
         S_COMPUTE: begin
            acc_d = sum_c;
            if (row_q == RW'(N - 1)) begin
               state_d     = S_OUTPUT;
               out_valid_d = 1'b1;
               out_data_d  = sum_c;
               out_idx_d   = col_q;
               out_last_d  = (col_q == RW'(N - 1));
            end else begin
               row_d = row_q + RW'(1);
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (out_last) begin
                  state_d    = S_IDLE;
                  in_ready_d = 1'b1;
                  busy_d     = 1'b0;
               end else begin
                  col_d   = col_q + RW'(1);
                  row_d   = '0;
                  acc_d   = '0;
                  state_d = S_COMPUTE;
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mat_vec_engine.sv
// Self-checking bench for mat_vec_engine against a plain-arithmetic matrix model.
module tb_mat_vec_engine;

   localparam int N  = 6;
   localparam int DW = 8;
   localparam int RW = $clog2(N);
   localparam int AW = DW + RW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  in_vec = '0;
   logic          coef_we = 1'b0;
   logic [RW-1:0] coef_row = '0;
   logic [RW-1:0] coef_col = '0;
   logic [DW-1:0] coef_data = '0;
   logic          coef_err;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] out_data;
   logic [RW-1:0] out_idx;
   logic          out_last;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int unsigned m [N][N];

   mat_vec_engine #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .coef_we   (coef_we),
      .coef_row  (coef_row),
      .coef_col  (coef_col),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            m[i][j] = (i * 16 + j + 1) % 256;
   endfunction

   // Column j weighted by the vector bits.
   function automatic int unsigned model_r(input logic [N-1:0] v, input int j);
      int unsigned s = 0;
      for (int i = 0; i < N; i++)
         if (v[i]) s += m[i][j];
      return s;
   endfunction

   task automatic do_reset();
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic write_coef(input int row, input int col, input int data);
      coef_we   = 1'b1;
      coef_row  = RW'(row);
      coef_col  = RW'(col);
      coef_data = DW'(data);
      if (row < N && col < N && in_ready) m[row][col] = data % 256;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   // Push one vector, drain all N results, optionally with a coefficient write on the same edge.
   task automatic run_vector(input logic [N-1:0] vec, input int stall0, input bit pulse_we,
                             input bit wr_en, input int wr_row, input int wr_col, input int wr_data,
                             input bit noise);
      int cyc;
      int stall;
      logic [AW-1:0] exp_d;
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
         return;
      end
      in_valid = 1'b1;
      in_vec   = vec;
      if (wr_en) begin
         coef_we   = 1'b1;
         coef_row  = RW'(wr_row);
         coef_col  = RW'(wr_col);
         coef_data = DW'(wr_data);
         if (wr_row < N && wr_col < N) m[wr_row][wr_col] = wr_data % 256;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_accept: in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
      for (int j = 0; j < N; j++) begin
         exp_d = AW'(model_r(vec, j));
         // cyc counts cycles following the accepting edge, starting at 1.
         cyc = 1;
         while (out_valid !== 1'b1 && cyc <= 4 * N) begin
            if (noise) begin
               in_valid = 1'($urandom_range(0, 1));
               in_vec   = N'($urandom);
            end
            @(posedge clk); #1; cyc++;
         end
         in_valid = 1'b0;
         checks++;
         if (cyc !== N + 1) begin
            errors++;
            $display("FAIL latency idx%0d: out_valid in cycle %0d required %0d", j, cyc, N + 1);
            if (out_valid !== 1'b1) return;
         end
         stall = (j == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(0, 3));
         out_ready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            if (pulse_we && j == 0 && s == 2) begin
               coef_we   = 1'b1;
               coef_row  = '0;
               coef_col  = '0;
               coef_data = 8'h55;
            end
            @(posedge clk); #1;
            coef_we = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_idx !== RW'(j)) begin
               errors++;
               $display("FAIL stall_hold idx%0d: valid=%b data=%0d idx=%0d required 1/%0d/%0d",
                        j, out_valid, out_data, out_idx, exp_d, j);
            end
         end
         out_ready = 1'b1;
         checks++;
         if (out_data !== exp_d) begin
            errors++;
            $display("FAIL data idx%0d vec=%b: got %0d required %0d", j, vec, out_data, exp_d);
         end
         checks++;
         if (out_idx !== RW'(j) || out_last !== 1'(j == N - 1)) begin
            errors++;
            $display("FAIL idx_last idx%0d: idx=%0d last=%b required %0d/%b",
                     j, out_idx, out_last, j, (j == N - 1));
         end
         @(posedge clk); #1;
         out_ready = 1'b0;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop idx%0d: out_valid=%b required 0", j, out_valid);
         end
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_return: in_ready=%b busy=%b required 1/0", in_ready, busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b required 1/0/0",
                  in_ready, busy, out_valid);
      end
      checks++;
      if (out_data !== '0 || out_idx !== '0 || out_last !== 1'b0 || coef_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data=%0d idx=%0d last=%b err=%b required 0/0/0/0",
                  out_data, out_idx, out_last, coef_err);
      end
   endtask

   task automatic test_unit_vector();
      run_vector(6'b000001, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_all_ones();
      run_vector(6'b111111, -1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_coef_write();
      write_coef(2, 3, 8'hFF);
      run_vector(6'b000100, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      checks++;
      if (coef_err !== 1'b0) begin
         errors++;
         $display("FAIL coef_err_idle_write: got %b required 0", coef_err);
      end
   endtask

   task automatic test_simultaneous();
      run_vector(6'b000010, 0, 1'b0, 1'b1, 1, 4, 8'hA0, 1'b0);
      run_vector(6'b000001, 0, 1'b0, 1'b1, 0, 0, 8'h7E, 1'b0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 1)
            write_coef(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                       int'($urandom_range(0, 255)));
         run_vector(N'($urandom), -1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      end
   endtask

   task automatic test_stall_err();
      run_vector(N'($urandom), 5, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      checks++;
      if (coef_err !== 1'b1) begin
         errors++;
         $display("FAIL coef_err_busy_write: got %b required 1", coef_err);
      end
      run_vector(6'b000001, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      checks++;
      if (coef_err !== 1'b1) begin
         errors++;
         $display("FAIL coef_err_sticky: got %b required 1", coef_err);
      end
   endtask

   task automatic test_bad_addr();
      do_reset();
      write_coef(6, 0, 8'h11);
      checks++;
      if (coef_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_row: coef_err=%b required 1", coef_err);
      end
      do_reset();
      write_coef(1, 7, 8'h22);
      checks++;
      if (coef_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_col: coef_err=%b required 1", coef_err);
      end
      run_vector(6'b000010, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      write_coef(2, 3, 8'hFF);
      in_valid = 1'b1;
      in_vec   = 6'b111111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || coef_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b ready=%b busy=%b err=%b required 0/1/0/0",
                  out_valid, in_ready, busy, coef_err);
      end
      for (int c = 0; c < 2 * N + 4; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_residue cycle%0d: out_valid=%b required 0", c, out_valid);
         end
      end
      run_vector(6'b000001, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      run_vector(6'b000100, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_unit_vector();
      test_all_ones();
      test_coef_write();
      test_simultaneous();
      test_random();
      test_stall_err();
      test_bad_addr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
